// File: rtl/execute_stage.sv
// LC3 execute stage: operand forwarding, ALU, address adder and branch-condition decode,
// all results registered for the downstream stages and held while enable_execute is low.
module execute_stage #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable_execute,
  input  logic [1:0]            W_Control_in,
  input  logic                  Mem_Control_in,
  input  logic [5:0]            E_Control,
  input  logic [DATA_WIDTH-1:0] IR,
  input  logic [DATA_WIDTH-1:0] npc,
  input  logic [DATA_WIDTH-1:0] VSR1,
  input  logic [DATA_WIDTH-1:0] VSR2,
  input  logic [DATA_WIDTH-1:0] Mem_Bypass_Val,
  input  logic                  bypass_alu_1,
  input  logic                  bypass_alu_2,
  input  logic                  bypass_mem_1,
  input  logic                  bypass_mem_2,
  output logic [DATA_WIDTH-1:0] aluout,
  output logic [DATA_WIDTH-1:0] pcout,
  output logic [1:0]            W_Control_out,
  output logic                  Mem_Control_out,
  output logic [DATA_WIDTH-1:0] M_Data,
  output logic [2:0]            dr,
  output logic [2:0]            NZP,
  output logic [2:0]            sr1,
  output logic [2:0]            sr2
);
  localparam logic [3:0] OP_BR  = 4'b0000, OP_ADD = 4'b0001, OP_LD  = 4'b0010,
                         OP_AND = 4'b0101, OP_LDR = 4'b0110, OP_NOT = 4'b1001,
                         OP_LDI = 4'b1010, OP_JMP = 4'b1100, OP_LEA = 4'b1110;

  logic [1:0]            alu_control, pcselect1;
  logic                  pcselect2, op2select;
  logic [3:0]            opcode;
  logic [DATA_WIDTH-1:0] val1, val2, op2, alu_res, offset, base, addr;
  logic [2:0]            dr_next, nzp_next;
  logic                  is_alu;

  assign {alu_control, pcselect1, pcselect2, op2select} = E_Control;
  assign opcode = IR[15:12];
  assign sr1    = IR[8:6];
  assign sr2    = IR[2:0];

  // Forwarding: the stage's own registered result outranks the MemAccess value.
  always_comb begin
    val1 = bypass_alu_1 ? aluout : (bypass_mem_1 ? Mem_Bypass_Val : VSR1);
    val2 = bypass_alu_2 ? aluout : (bypass_mem_2 ? Mem_Bypass_Val : VSR2);
    op2  = op2select ? val2 : {{(DATA_WIDTH-5){IR[4]}}, IR[4:0]};
  end

  always_comb begin
    case (alu_control)
      2'b00:   alu_res = val1 + op2;
      2'b01:   alu_res = val1 & op2;
      2'b10:   alu_res = ~val1;
      default: alu_res = val1;
    endcase
  end

  always_comb begin
    case (pcselect1)
      2'b00:   offset = {{(DATA_WIDTH-11){IR[10]}}, IR[10:0]};
      2'b01:   offset = {{(DATA_WIDTH-9){IR[8]}},  IR[8:0]};
      2'b10:   offset = {{(DATA_WIDTH-6){IR[5]}},  IR[5:0]};
      default: offset = '0;
    endcase
    base = pcselect2 ? npc : val1;
    addr = offset + base;
  end

  always_comb begin
    is_alu = (opcode == OP_ADD) || (opcode == OP_AND) || (opcode == OP_NOT);
    case (opcode)
      OP_ADD, OP_AND, OP_NOT, OP_LD, OP_LDR, OP_LDI, OP_LEA: dr_next = IR[11:9];
      default:                                               dr_next = 3'd0;
    endcase
    case (opcode)
      OP_BR:   nzp_next = IR[11:9];
      OP_JMP:  nzp_next = 3'b111;
      default: nzp_next = 3'b000;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      aluout          <= '0;
      pcout           <= '0;
      W_Control_out   <= '0;
      Mem_Control_out <= 1'b0;
      M_Data          <= '0;
      dr              <= '0;
      NZP             <= '0;
    end else if (enable_execute) begin
      aluout          <= is_alu ? alu_res : addr;
      pcout           <= addr;
      W_Control_out   <= W_Control_in;
      Mem_Control_out <= Mem_Control_in;
      M_Data          <= val2;
      dr              <= dr_next;
      NZP             <= nzp_next;
    end
  end
endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- LC3 Execute pipeline stage: the consumer end of the execute_in bus.
- Takes decoded control, instruction, operand and bypass signals from Decode/Writeback/Controller.
- Computes the ALU result, memory/branch address, destination register and branch condition.
- Registers all results for the MemAccess/Writeback/Fetch stages, with one-cycle latency gated by enable_execute.

Parameters:
- DATA_WIDTH, 16, datapath width; only 16 is supported (the LC3 ISA is fixed).

Ports:
clock  input  1  stage clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
enable_execute  input  1  when 1, registered outputs update this edge
W_Control_in  input  2  writeback mux select, passed through
Mem_Control_in  input  1  memory access control, passed through
E_Control  input  6  [5:4] alu_control, [3:2] pcselect1, [1] pcselect2, [0] op2select
IR  input  16  instruction
npc  input  16  PC+1 of the instruction
VSR1  input  16  register-file value of source 1
VSR2  input  16  register-file value of source 2 / store data
Mem_Bypass_Val  input  16  forwarded value from MemAccess
bypass_alu_1  input  1  forward previous aluout to operand 1
bypass_alu_2  input  1  forward previous aluout to operand 2
bypass_mem_1  input  1  forward Mem_Bypass_Val to operand 1
bypass_mem_2  input  1  forward Mem_Bypass_Val to operand 2
aluout  output  16  registered ALU result or computed address
pcout  output  16  registered address-adder result
W_Control_out  output  2  registered W_Control_in
Mem_Control_out  output  1  registered Mem_Control_in
M_Data  output  16  registered store data (operand 2 after bypass)
dr  output  3  registered destination register
NZP  output  3  registered branch condition mask
sr1  output  3  combinational IR[8:6]
sr2  output  3  combinational IR[2:0]

Behaviour:
- Reset (reset=0, asynchronous): aluout, pcout, M_Data = 16'h0000; W_Control_out = 0; Mem_Control_out = 0; dr = 0; NZP = 0. Reset mid-operation discards the in-flight result. Outputs stay 0 until the first enabled edge after reset deasserts.
- Latency: inputs sampled at rising edge with enable_execute=1 appear on registered outputs after that edge.
- enable_execute=0: all registered outputs hold their previous values, including during back-to-back stalls.
- Operand forwarding:
  - val1 = bypass_alu_1 ? aluout(current reg) : bypass_mem_1 ? Mem_Bypass_Val : VSR1.
  - val2 uses the same rule with the _2 signals and VSR2.
  - ALU bypass wins when both bypass signals are set.
- op2 = op2select ? val2 : sext(IR[4:0]).
- ALU, selected by alu_control:
  - 00: val1 + op2, modulo 2^16 (carry discarded).
  - 01: val1 & op2.
  - 10: ~val1.
  - 11: reserved; produces val1.
- Address adder: offset + base.
  - Offset by pcselect1: 00 sext(IR[10:0]), 01 sext(IR[8:0]), 10 sext(IR[5:0]), 11 zero.
  - Base: pcselect2=1 selects npc, 0 selects val1.
  - Modulo 2^16; wraps from 16'hFFFF to 0.
- aluout: ALU result when IR[15:12] is ADD (0001), AND (0101) or NOT (1001); otherwise the address-adder result.
- pcout: always the address-adder result.
- M_Data: val2.
- dr: IR[11:9] for ADD, AND, NOT, LD (0010), LDR (0110), LDI (1010), LEA (1110); 0 for all other opcodes.
- NZP:
  - IR[11:9] for BR (0000).
  - 3'b111 for JMP/RET (1100).
  - 0 otherwise.
- sr1, sr2: purely combinational from the current IR; unaffected by enable_execute and reset.
- No internal state beyond the output registers. Self-forwarding uses the registered aluout.

Test Plan:
- ADD immediate: reset released; IR=16'h1263, VSR1=16'h0005, E_Control=6'b000000, enable=1 -> next cycle aluout=16'h0008, dr=3'd1, NZP=0.
- AND with ALU bypass: previous aluout=16'h00F0; IR=16'h5042, VSR1=16'hFFFF, VSR2=16'h0F3C, bypass_alu_1=1, E_Control=6'b010001 -> aluout=16'h0030, dr=0, sr1=1, sr2=2.
- Bypass priority: bypass_alu_2=1 and bypass_mem_2=1, aluout=16'h1111, Mem_Bypass_Val=16'h2222 -> M_Data=16'h1111. With bypass_mem_2 only -> M_Data=16'h2222.
- Branch: IR=16'h0A05, npc=16'h3001, E_Control=6'b000110 -> pcout=16'h3006, aluout=16'h3006, NZP=3'b101, dr=0. Same test with npc=16'hFFFE -> pcout=16'h0003 (wrap).
- Stall: load ADD result; drive enable_execute=0 for 3 cycles while changing all inputs -> all registered outputs unchanged; sr1/sr2 track IR.
- Reset mid-operation: assert reset=0 between edges while outputs are nonzero -> all registered outputs 0 immediately, without waiting for a clock edge. They remain 0 until enabled again after release.
